// File: rtl/subterranean_serial_bridge.sv
// Word-to-bit bridge around the bit-serial Subterranean round core: loads 257 state bits, runs the round, repacks the result.
// Optional SUBTERRANEAN_BRIDGE_MULTI_ROUND_EN adds n_rounds_i to chain several rounds per block.
module subterranean_serial_bridge #(
  parameter int STATE_W = 257,
  parameter int WORD_W  = 32
) (
  input  logic              clk,
  input  logic              arstn,
`ifdef SUBTERRANEAN_BRIDGE_MULTI_ROUND_EN
  input  logic [3:0]        n_rounds_i,
`endif
  input  logic [WORD_W-1:0] s_word_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic [WORD_W-1:0] m_word_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              core_data_in_o,
  output logic              core_data_in_valid_o,
  input  logic              core_data_in_ready_i,
  input  logic              core_data_out_i,
  input  logic              core_data_out_valid_i,
  output logic              core_data_out_ready_o,
  output logic              core_start_o,
  input  logic              core_finish_i
);

  localparam int NWORDS = (STATE_W + WORD_W - 1) / WORD_W;
  localparam int CNT_W  = $clog2(STATE_W + 1);
  localparam int SH_W   = $clog2(WORD_W + 1);
  localparam int WC_W   = $clog2(NWORDS + 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, READ} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [SH_W-1:0]   shcnt_q, shcnt_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WC_W-1:0]   words_in_q, words_in_d;
  logic [CNT_W-1:0]  bits_left_q, bits_left_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [SH_W-1:0]   asm_cnt_q, asm_cnt_d;
  logic [WORD_W-1:0] m_word_q, m_word_d;
  logic              m_valid_q, m_valid_d;
  logic              more_rounds;
  logic              asm_full;
  logic              in_fire;
  logic              capture;
  logic [SH_W-1:0]   fin_shift;

`ifdef SUBTERRANEAN_BRIDGE_MULTI_ROUND_EN
  logic [3:0] rounds_q, rounds_d;
  assign more_rounds = (rounds_q > 4'd1);
`else
  assign more_rounds = 1'b0;
`endif

  // The next capture closes a word, so it must wait until the output register is free.
  assign asm_full  = (asm_cnt_q == SH_W'(WORD_W - 1)) || (bits_left_q == CNT_W'(1));
  assign fin_shift = SH_W'(WORD_W - 1) - asm_cnt_q;

  assign m_word_o       = m_word_q;
  assign m_valid_o      = m_valid_q;
  assign core_data_in_o = shreg_q[0];

  always_comb begin
    state_d               = state_q;
    shreg_d               = shreg_q;
    shcnt_d               = shcnt_q;
    bit_cnt_d             = bit_cnt_q;
    words_in_d            = words_in_q;
    bits_left_d           = bits_left_q;
    asm_d                 = asm_q;
    asm_cnt_d             = asm_cnt_q;
    m_word_d              = m_word_q;
    m_valid_d             = m_valid_q;
`ifdef SUBTERRANEAN_BRIDGE_MULTI_ROUND_EN
    rounds_d              = rounds_q;
`endif
    s_ready_o             = 1'b0;
    core_data_in_valid_o  = 1'b0;
    core_data_out_ready_o = 1'b0;
    core_start_o          = 1'b0;
    in_fire               = 1'b0;
    capture               = 1'b0;

    if (m_valid_q && m_ready_i) m_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        s_ready_o = 1'b1;
        if (s_valid_i) begin
          shreg_d    = s_word_i;
          shcnt_d    = SH_W'(WORD_W);
          bit_cnt_d  = '0;
          words_in_d = WC_W'(1);
`ifdef SUBTERRANEAN_BRIDGE_MULTI_ROUND_EN
          rounds_d   = (n_rounds_i == 4'd0) ? 4'd1 : n_rounds_i;
`endif
          state_d    = LOAD;
        end
      end
      LOAD: begin
        in_fire              = (shcnt_q != '0) && core_data_in_ready_i;
        core_data_in_valid_o = in_fire;
        if (in_fire) begin
          shreg_d   = shreg_q >> 1;
          shcnt_d   = shcnt_q - SH_W'(1);
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(STATE_W - 1)) state_d = START;
        end
        // A new word may replace the one whose last bit leaves this cycle; the final word contributes only bit 0.
        s_ready_o = (words_in_q != WC_W'(NWORDS)) &&
                    ((shcnt_q == '0) || ((shcnt_q == SH_W'(1)) && in_fire));
        if (s_ready_o && s_valid_i) begin
          shreg_d    = s_word_i;
          shcnt_d    = (words_in_q == WC_W'(NWORDS - 1)) ? SH_W'(1) : SH_W'(WORD_W);
          words_in_d = words_in_q + WC_W'(1);
        end
      end
      START: begin
        core_start_o = 1'b1;
        state_d      = WAIT;
      end
      WAIT: begin
        if (core_finish_i) begin
          if (more_rounds) begin
            state_d = START;
`ifdef SUBTERRANEAN_BRIDGE_MULTI_ROUND_EN
            rounds_d = rounds_q - 4'd1;
`endif
          end else begin
            state_d     = READ;
            bits_left_d = CNT_W'(STATE_W);
            asm_cnt_d   = '0;
            asm_d       = '0;
          end
        end
      end
      READ: begin
        core_data_out_ready_o = (bits_left_q != '0) && !(asm_full && m_valid_q && !m_ready_i);
        capture               = core_data_out_valid_i && core_data_out_ready_o;
        if (capture) begin
          bits_left_d = bits_left_q - CNT_W'(1);
          if (asm_full) begin
            m_word_d  = {core_data_out_i, asm_q[WORD_W-1:1]} >> fin_shift;
            m_valid_d = 1'b1;
            asm_d     = '0;
            asm_cnt_d = '0;
          end else begin
            asm_d     = {core_data_out_i, asm_q[WORD_W-1:1]};
            asm_cnt_d = asm_cnt_q + SH_W'(1);
          end
        end
        if ((bits_left_q == '0) && m_valid_q && m_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      shcnt_q     <= '0;
      bit_cnt_q   <= '0;
      words_in_q  <= '0;
      bits_left_q <= '0;
      asm_q       <= '0;
      asm_cnt_q   <= '0;
      m_word_q    <= '0;
      m_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      shcnt_q     <= shcnt_d;
      bit_cnt_q   <= bit_cnt_d;
      words_in_q  <= words_in_d;
      bits_left_q <= bits_left_d;
      asm_q       <= asm_d;
      asm_cnt_q   <= asm_cnt_d;
      m_word_q    <= m_word_d;
      m_valid_q   <= m_valid_d;
    end
  end

`ifdef SUBTERRANEAN_BRIDGE_MULTI_ROUND_EN
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) rounds_q <= 4'd0;
    else        rounds_q <= rounds_d;
  end
`endif

endmodule
